scan_test_controller: RTL and testbench
=======================================

Name: scan_test_controller

Overview:
- Upstream driver for the 8-flop scan-chain multiplier (4-bit a, 4-bit b, 8-bit product capture).
- On start, serialises operands into the chain with scan_en=1 and pulses one capture cycle with scan_en=0.
- Then shifts the captured product out, deserialises it, and checks it against an internally computed golden a*b.
- Sits between the test sequencer (parallel operands, start/done) and the chain's scan_in/scan_en/scan_out pins.

Parameters:
- A_W, 4, operand a width.
- B_W, 4, operand b width.
- CHAIN_LEN, A_W+B_W, number of scan flops shifted in; also the product width P_W.
- FILL_BIT, 1'b0, value driven on scan_in during shift-out.

Ports:
- clk  in  1  rising-edge clock shared with the chain
- rst  in  1  synchronous, active-high reset
- start  in  1  request one test pattern; sampled only in IDLE or DONE
- a  in  A_W  operand a, latched on accepted start
- b  in  B_W  operand b, latched on accepted start
- scan_out  in  1  serial output of the chain's last flop
- scan_in  out  1  serial data into the chain (registered)
- scan_en  out  1  1 = shift, 0 = capture (registered)
- busy  out  1  high from the first SHIFT_IN cycle through the last SHIFT_OUT cycle
- done  out  1  one-cycle pulse when product and pass are valid
- product  out  CHAIN_LEN  deserialised captured product, held until the next accepted start
- pass  out  1  product == a_lat*b_lat; valid while done is high and held afterwards

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - state=IDLE, scan_in=0, scan_en=0, busy=0, done=0, product=0, pass=0, counters=0.
  - Applies identically mid-operation; the partial pattern is discarded.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - scan_en=0.
  - On start=1, latch a and b, clear the bit counter, and go to SHIFT_IN.
- SHIFT_IN (CHAIN_LEN cycles, k=0..CHAIN_LEN-1):
  - scan_en=1.
  - scan_in order is b[0..B_W-1] first, then a[0..A_W-1] (b0 enters first).
  - After k=CHAIN_LEN-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - scan_en=0, scan_in=FILL_BIT.
  - The chain loads a*b at the edge ending this cycle.
- SHIFT_OUT (CHAIN_LEN cycles):
  - scan_en=1, scan_in=FILL_BIT.
  - At the edge ending cycle k, scan_out is sampled into the shift register as product bit k (p0 first, LSB-first).
  - After k=CHAIN_LEN-1, go to DONE.
- DONE (1 cycle):
  - done=1, scan_en=0.
  - product is updated, and pass = (product == golden), where golden is a_lat*b_lat computed at full CHAIN_LEN width with no truncation.
  - start=1 in this cycle is accepted: go directly to SHIFT_IN with new operands (back-to-back patterns).
  - Otherwise go to IDLE.
- Latency: start accepted at edge T; first shift bit is driven in cycle T+1; done is high in cycle T+1+2*CHAIN_LEN+1 (cycle T+18 for defaults).
- Input handling:
  - start while busy is ignored, with no effect on the operand latches.
  - a and b changing after acceptance have no effect.
- Outputs are registered only; no combinational path from scan_out to any output.

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE};
  - default widths A_W/B_W/CHAIN_LEN;
  - function pack_chain(a,b) that returns the shift-in bit vector in chain order.
- One natural sub-module, scan_deserializer: a CHAIN_LEN-bit LSB-first shift register with an enable and a clear.
- FSM, counter and golden multiply stay in the top module.

Test Plan:
- a=5, b=6, bench chain model attached -> scan_in sequence 0,1,1,0,1,0,1,0 in cycles T+1..T+8; scan_en=0 in T+9; done in T+18; product=8'h1E; pass=1.
- a=15, b=15 -> product=8'hE1, pass=1; a=0, b=9 -> product=8'h00, pass=1.
- Chain model with product bit 3 stuck-at-0, a=3, b=5 -> product=8'h07, pass=0, done still pulses once.
- rst=1 during the 4th SHIFT_IN cycle -> next cycle scan_en=0, scan_in=0, busy=0, done=0, product=0; a fresh start then completes normally.
- start held high continuously with a=2, b=3 then a=4, b=4 -> second pattern's first shift cycle immediately follows DONE; products 8'h06 then 8'h10, each with a single done pulse; mid-busy start pulses ignored.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan-chain multiplier test controller.
// pack_chain fixes the order in which operand bits enter the chain.
package scan_pkg;

  localparam int DEF_A_W       = 4;
  localparam int DEF_B_W       = 4;
  localparam int DEF_CHAIN_LEN = DEF_A_W + DEF_B_W;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  // Bit k of the result is the bit driven on scan_in in shift cycle k: b0 first, a last.
  function automatic logic [DEF_CHAIN_LEN-1:0] pack_chain(
    input logic [DEF_A_W-1:0] a,
    input logic [DEF_B_W-1:0] b
  );
    return {a, b};
  endfunction

endpackage

// File: rtl/scan_deserializer.sv
// LSB-first shift register: each enabled edge inserts a bit at the MSB,
// so after CHAIN_LEN shifts the first bit received sits in bit 0.
module scan_deserializer #(
  parameter int CHAIN_LEN = scan_pkg::DEF_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_bit,
  output logic [CHAIN_LEN-1:0] o_data
);

  logic [CHAIN_LEN-1:0] r_sr;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= {i_bit, r_sr[CHAIN_LEN-1:1]};
    end
  end

  assign o_data = r_sr;

endmodule

// File: rtl/scan_test_controller.sv
// Drives one test pattern through the scan-chain multiplier: shift operands in,
// capture once, shift the product out and compare it against a golden a*b.
module scan_test_controller
  import scan_pkg::*;
#(
  parameter int   A_W       = DEF_A_W,
  parameter int   B_W       = DEF_B_W,
  parameter int   CHAIN_LEN = A_W + B_W,
  parameter logic FILL_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic                 scan_out,
  output logic                 scan_in,
  output logic                 scan_en,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] product,
  output logic                 pass
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [A_W-1:0]       r_a;
  logic [B_W-1:0]       r_b;
  logic [CHAIN_LEN-1:0] r_pattern;
  logic                 r_scan_in;
  logic                 r_scan_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;

  logic                 w_accept;
  logic [CHAIN_LEN-1:0] w_chain;
  logic [CHAIN_LEN-1:0] w_golden;
  logic [CHAIN_LEN-1:0] w_sr;
  logic [CHAIN_LEN-1:0] w_captured;

  assign w_accept   = start && (r_state == IDLE || r_state == DONE);
  assign w_chain    = pack_chain(a, b);
  assign w_golden   = CHAIN_LEN'(r_a) * CHAIN_LEN'(r_b);
  // Value the deserializer will hold after the final SHIFT_OUT edge.
  assign w_captured = {scan_out, w_sr[CHAIN_LEN-1:1]};

  scan_deserializer #(.CHAIN_LEN(CHAIN_LEN)) u_deser (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (r_state == SHIFT_OUT),
    .i_bit  (scan_out),
    .o_data (w_sr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_pattern <= '0;
      r_scan_in <= 1'b0;
      r_scan_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_scan_en <= 1'b0;
          r_scan_in <= FILL_BIT;
          r_state   <= IDLE;
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_scan_in <= w_chain[0];
            r_pattern <= w_chain >> 1;
            r_scan_en <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_state   <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (r_cnt == LAST) begin
            r_scan_en <= 1'b0;
            r_scan_in <= FILL_BIT;
            r_cnt     <= '0;
            r_state   <= CAPTURE;
          end else begin
            r_scan_in <= r_pattern[0];
            r_pattern <= r_pattern >> 1;
            r_cnt     <= r_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          r_scan_en <= 1'b1;
          r_scan_in <= FILL_BIT;
          r_state   <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (r_cnt == LAST) begin
            r_scan_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= (w_captured == w_golden);
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign scan_in = r_scan_in;
  assign scan_en = r_scan_en;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = w_sr;
  assign pass    = r_pass;

endmodule

// File: tb/tb_scan_test_controller.sv
// Scoreboard bench: a behavioural 8-flop multiplier chain is attached to the DUT;
// expected product/pass are queued at start and popped by a done monitor.
module tb_scan_test_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       scan_out;
  logic       scan_in;
  logic       scan_en;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       pass;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] p;
    logic       ok;
  } exp_t;
  exp_t sb[$];

  // Chain model: scan_in enters flop 0, flop 7 drives scan_out.
  logic [7:0] chain = '0;
  logic       stuck3 = 1'b0;

  always #5 clk = ~clk;

  scan_test_controller dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .scan_out (scan_out),
    .scan_in  (scan_in),
    .scan_en  (scan_en),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .pass     (pass)
  );

  assign scan_out = chain[7];

  always @(posedge clk) begin
    logic [3:0] ma, mb;
    logic [7:0] mp, rev;
    if (scan_en) begin
      chain <= {chain[6:0], scan_in};
    end else begin
      mb = {chain[4], chain[5], chain[6], chain[7]};
      ma = {chain[0], chain[1], chain[2], chain[3]};
      mp = 8'(ma) * 8'(mb);
      if (stuck3) mp[3] = 1'b0;
      for (int i = 0; i < 8; i++) rev[7-i] = mp[i];
      chain <= rev;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.p));
        check("pass", 32'(pass), 32'(e.ok));
      end
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [3:0] av, input logic [3:0] bv,
                       input logic [7:0] ep, input logic eok);
    @(posedge clk); #1;
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    sb.push_back('{p: ep, ok: eok});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] seq;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_scan_in", 32'(scan_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);

    // 5*6: shift order b0..b3 then a0..a3, with cycle-exact latency checks.
    seq = 8'b0101_0110;
    issue(4'd5, 4'd6, 8'h1E, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("shift_in_bit%0d", k), 32'(scan_in), 32'(seq[k]));
      check("shift_in_en", 32'(scan_en), 32'd1);
      check("shift_in_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("capture_en", 32'(scan_en), 32'd0);
    for (int t = 10; t <= 18; t++) begin
      @(negedge clk);
      if (t == 17) check("done_early", 32'(done), 32'd0);
      if (t == 18) check("done_at_t18", 32'(done), 32'd1);
    end

    issue(4'd15, 4'd15, 8'hE1, 1'b1);
    wait_done();
    issue(4'd0, 4'd9, 8'h00, 1'b1);
    wait_done();

    // Chain fault: product bit 3 stuck-at-0.
    stuck3 = 1'b1;
    issue(4'd3, 4'd5, 8'h07, 1'b0);
    wait_done();
    @(negedge clk);
    check("fault_done_single", 32'(done), 32'd0);
    stuck3 = 1'b0;

    // Reset in the 4th SHIFT_IN cycle discards the pattern.
    @(posedge clk); #1;
    a_i = 4'd7; b_i = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_scan_en", 32'(scan_en), 32'd0);
    check("mid_rst_scan_in", 32'(scan_in), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    issue(4'd9, 4'd7, 8'h3F, 1'b1);
    wait_done();

    // start held high: operands change after acceptance and mid-busy starts are ignored.
    @(posedge clk); #1;
    a_i = 4'd2; b_i = 4'd3; start = 1'b1;
    sb.push_back('{p: 8'h06, ok: 1'b1});
    sb.push_back('{p: 8'h10, ok: 1'b1});
    @(posedge clk); #1;
    a_i = 4'd4; b_i = 4'd4;
    wait_done();
    check("b2b_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_shift_busy", 32'(busy), 32'd1);
    check("b2b_shift_en", 32'(scan_en), 32'd1);
    check("b2b_shift_bit0", 32'(scan_in), 32'd0);
    wait_done();
    start = 1'b0;
    @(negedge clk);
    check("b2b_no_restart", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
